// File: rtl/uut_serial_sub_pkg.sv
// Shared definitions for the serial subtractor and its borrow-ripple slice.
//   state_t     : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   diff_bit    : per-bit difference a ^ b ^ br
//   borrow_bit  : per-bit borrow out of a - b - br
package uut_serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic diff_bit(input logic a, input logic b, input logic br);
    return a ^ b ^ br;
  endfunction

  function automatic logic borrow_bit(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/uut_sub_slice.sv
// Combinational CHUNK-bit borrow-ripple subtractor slice: d = a - b - bin.
//   a, b : slice operands
//   bin  : borrow into bit 0
//   d    : slice difference
//   bout : borrow out of the slice MSB
module uut_sub_slice
  import uut_serial_sub_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  // br[i] is the borrow entering bit i
  logic [CHUNK:0] br;

  assign br[0] = bin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign d[i]    = diff_bit(a[i], b[i], br[i]);
    assign br[i+1] = borrow_bit(a[i], b[i], br[i]);
  end

  assign bout = br[CHUNK];

endmodule

// File: rtl/uut_serial_sub.sv
// Multi-cycle subtractor: y = a - b - bin (mod 2^WIDTH), CHUNK bits per clock,
// LSB slice first, with the inter-slice borrow held in a register.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin an operation (accepted in IDLE or DONE)
//   a, b, bin: operands, sampled on the accepted start
//   busy     : high while slices are processed
//   done     : one-cycle pulse when y/bout become valid
//   y, bout  : difference and borrow-out, held until the next result
module uut_serial_sub
  import uut_serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bout
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   br;
  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       acc;
  logic [CHUNK-1:0]       d_slc;
  logic                   bout_slc;
  logic [WIDTH+CHUNK-1:0] acc_cat;
  logic [WIDTH-1:0]       acc_nxt;
  logic                   accept;
  logic                   last_slice;

  // A start is honoured whenever no operation is in flight (IDLE or DONE)
  assign accept     = start && (state != RUN);
  assign last_slice = (state == RUN) && (cnt == LAST);

  uut_sub_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .bin  (br),
    .d    (d_slc),
    .bout (bout_slc)
  );

  // New slice enters at the MSB end; after N shifts acc holds the full result
  assign acc_cat = {d_slc, acc};
  assign acc_nxt = acc_cat[WIDTH+CHUNK-1:CHUNK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Control and visible result; y/bout only move on the RUN->DONE edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      br   <= 1'b0;
      y    <= '0;
      bout <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= '0;
        br  <= bin;
      end else if (state == RUN) begin
        cnt <= cnt + CNT_W'(1);
        br  <= bout_slc;
      end
      if (last_slice) begin
        y    <= acc_nxt;
        bout <= bout_slc;
      end
    end
  end

  // Operand shift registers and partial result; no reset needed since a
  // fresh operation overwrites every bit before it is used
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == RUN) begin
      a_sh <= a_sh >> CHUNK;
      b_sh <= b_sh >> CHUNK;
      acc  <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_uut_serial_sub.sv
// Scoreboard bench for uut_serial_sub over several (WIDTH, CHUNK) configurations.
module tb_uut_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit fin_v [5];

  task automatic chk(input int cfg, input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cfg%0d: actual=%0h required=%0h at %0t", nm, cfg, act, req, $time);
    end
  endtask

  function automatic int cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 8;
      2: return 8;
      3: return 12;
      default: return 1;
    endcase
  endfunction

  function automatic int cfg_c(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 8;
      3: return 3;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int C = cfg_c(g);
    localparam int N = W / C;

    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         bin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, bout;
    logic [W-1:0] y;

    int cyc = 0;        // rising edges seen so far
    int next_ok = 0;    // earliest edge at which the model accepts a start
    int nacc = 0;
    logic [W-1:0] qy [$];
    logic         qb [$];
    int           qt [$];
    logic [W-1:0] last_y = '0;
    logic         last_b = 1'b0;

    uut_serial_sub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .y(y), .bout(bout)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of inputs at a falling edge; model acceptance and result
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi);
      int e;
      int d;
      start = s; a = av; b = bv; bin = bi;
      e = cyc + 1;
      if (s && e >= next_ok) begin
        d = int'(av) - int'(bv) - int'(bi);
        qy.push_back(W'(d));
        qb.push_back(d < 0);
        qt.push_back(e + N);
        next_ok = e + N + 1;
        nacc++;
      end
      @(negedge clk);
    endtask

    task automatic drive_rand(input int pct_start);
      drive($urandom_range(0, 99) < pct_start, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle();
      int n = 0;
      while (qt.size() > 0 && n < 300) begin
        drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
        n++;
      end
      chk(g, "drain", qt.size(), 0);
    endtask

    // Monitor: compare every done against the scoreboard, plus busy and hold
    always @(posedge clk) begin
      #1;
      if (!rst) begin
        chk(g, "busy_done_excl", busy && done, 0);
        if (qt.size() > 0 && cyc > qt[0]) begin
          chk(g, "missing_done", cyc, qt[0]);
          void'(qy.pop_front()); void'(qb.pop_front()); void'(qt.pop_front());
        end
        if (done) begin
          if (qt.size() == 0) begin
            chk(g, "unexpected_done", 1, 0);
          end else begin
            last_y = qy.pop_front();
            last_b = qb.pop_front();
            chk(g, "latency", cyc, qt.pop_front());
            chk(g, "y", y, last_y);
            chk(g, "bout", bout, last_b);
          end
        end else begin
          chk(g, "busy", busy, qt.size() > 0 && cyc >= qt[0] - N && cyc < qt[0]);
          chk(g, "y_hold", y, last_y);
          chk(g, "bout_hold", bout, last_b);
        end
      end
    end

    initial begin
      @(negedge clk);
      chk(g, "rst_busy", busy, 0);
      chk(g, "rst_done", done, 0);
      chk(g, "rst_y", y, 0);
      chk(g, "rst_bout", bout, 0);
      @(negedge clk);
      rst = 1'b0;
      next_ok = 0;
      if (g == 0) begin
        drive(1'b1, W'(8'h35), W'(8'h12), 1'b0);
        wait_idle();
        drive(1'b1, W'(8'h00), W'(8'h01), 1'b0);
        wait_idle();
        drive(1'b1, W'(8'h80), W'(8'h80), 1'b1);
        wait_idle();
        // start held high with operands changing every cycle
        for (int i = 0; i < 22; i++) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        wait_idle();
        // reset during the second RUN cycle
        drive(1'b1, W'(8'hF0), W'(8'h0F), 1'b0);
        drive(1'b0, W'(8'h00), W'(8'h00), 1'b0);
        rst = 1'b1;
        #1;
        chk(g, "midrst_busy", busy, 0);
        chk(g, "midrst_done", done, 0);
        chk(g, "midrst_y", y, 0);
        chk(g, "midrst_bout", bout, 0);
        qy.delete(); qb.delete(); qt.delete();
        last_y = '0; last_b = 1'b0; next_ok = 0;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, W'(8'h10), W'(8'h01), 1'b0);
        wait_idle();
        for (int i = 0; i < 400; i++) drive_rand(40);
        wait_idle();
      end else begin
        while (nacc < 500 && cyc < 60000) drive_rand(50);
        wait_idle();
        chk(g, "ops", nacc >= 500, 1);
      end
      fin_v[g] = 1'b1;
    end
  end

  initial begin
    int t = 0;
    bit all_fin = 1'b0;
    while (!all_fin && t < 90000) begin
      @(posedge clk);
      t++;
      all_fin = 1'b1;
      for (int i = 0; i < 5; i++) if (!fin_v[i]) all_fin = 1'b0;
    end
    chk(-1, "finish", all_fin, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
